// File: rtl/calc_op_sequencer_if.sv
// Memory request/acknowledge bus between the operation sequencer (master) and
// the shared operand memory (slave).
interface calc_op_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  MemAccess;
    logic                  MemRW;
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic [DATA_WIDTH-1:0] MemWData;
    logic [DATA_WIDTH-1:0] MemRData;
    logic                  MemAck;

    modport master (
        output MemAccess, MemRW, MemAddr, MemWData,
        input  MemRData, MemAck
    );

    modport slave (
        input  MemAccess, MemRW, MemAddr, MemWData,
        output MemRData, MemAck
    );
endinterface

// File: rtl/calc_op_sequencer.sv
// Sequences one calculator operation: read A, read B, run the external ALU,
// write the result back, with a per-access acknowledge timeout.
module calc_op_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Active,
    input  logic                  Start,
    input  logic [2:0]            Opcode,
    input  logic [ADDR_WIDTH-1:0] AddrA,
    input  logic [ADDR_WIDTH-1:0] AddrB,
    input  logic [ADDR_WIDTH-1:0] AddrR,
    calc_op_sequencer_if.master   bus,
    output logic [2:0]            AluOp,
    output logic [DATA_WIDTH-1:0] AluA,
    output logic [DATA_WIDTH-1:0] AluB,
    input  logic [DATA_WIDTH-1:0] AluResult,
    input  logic                  AluFlag,
    output logic                  Flag,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_WR_R, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
    logic [ADDR_WIDTH-1:0] addr_r_q, addr_r_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  flag_q, flag_d;
    logic                  err_q, err_d;
    logic                  timeout_hit;

    // Last waiting cycle: the edge that ends it moves to DONE unless acked.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        addr_r_d = addr_r_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        flag_d   = flag_q;
        err_d    = err_q;

        if (state_q != S_IDLE && !Active) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start && Active) begin
                        op_d     = Opcode;
                        addr_a_d = AddrA;
                        addr_b_d = AddrB;
                        addr_r_d = AddrR;
                        err_d    = 1'b0;
                        flag_d   = 1'b0;
                        cnt_d    = '0;
                        state_d  = S_RD_A;
                    end
                end
                S_RD_A, S_RD_B, S_WR_R: begin
                    if (bus.MemAck) begin
                        cnt_d = '0;
                        if (state_q == S_RD_A) begin
                            a_d     = bus.MemRData;
                            state_d = S_RD_B;
                        end else if (state_q == S_RD_B) begin
                            b_d     = bus.MemRData;
                            state_d = S_EXEC;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else if (timeout_hit) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_EXEC: begin
                    res_d   = AluResult;
                    flag_d  = AluFlag;
                    cnt_d   = '0;
                    state_d = S_WR_R;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_r_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            addr_r_q <= addr_r_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            flag_q   <= flag_d;
            err_q    <= err_d;
        end
    end

    // All outputs decode from state and latched registers only.
    always_comb begin
        bus.MemAccess = 1'b0;
        bus.MemRW     = 1'b0;
        bus.MemAddr   = '0;
        case (state_q)
            S_RD_A: begin
                bus.MemAccess = 1'b1;
                bus.MemAddr   = addr_a_q;
            end
            S_RD_B: begin
                bus.MemAccess = 1'b1;
                bus.MemAddr   = addr_b_q;
            end
            S_WR_R: begin
                bus.MemAccess = 1'b1;
                bus.MemRW     = 1'b1;
                bus.MemAddr   = addr_r_q;
            end
            default: begin
                bus.MemAccess = 1'b0;
            end
        endcase
    end

    assign bus.MemWData = res_q;
    assign AluOp        = op_q;
    assign AluA         = a_q;
    assign AluB         = b_q;
    assign Flag         = flag_q;
    assign Error        = err_q;
    assign Done         = (state_q == S_DONE);
    assign Busy         = (state_q == S_RD_A) || (state_q == S_RD_B) ||
                          (state_q == S_EXEC) || (state_q == S_WR_R);
endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed and randomized checks of calc_op_sequencer against a memory
// responder, an ALU model and a per-operation latency/result reference.
module tb_calc_op_sequencer;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int TO = 15;

    logic          Clk = 1'b0;
    logic          Reset, Active, Start;
    logic [2:0]    Opcode;
    logic [AW-1:0] AddrA, AddrB, AddrR;
    logic [2:0]    AluOp;
    logic [DW-1:0] AluA, AluB, AluResult;
    logic          AluFlag, Flag, Busy, Done, Error;

    calc_op_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    calc_op_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset), .Active(Active), .Start(Start),
        .Opcode(Opcode), .AddrA(AddrA), .AddrB(AddrB), .AddrR(AddrR),
        .bus(bus.master),
        .AluOp(AluOp), .AluA(AluA), .AluB(AluB), .AluResult(AluResult),
        .AluFlag(AluFlag), .Flag(Flag), .Busy(Busy), .Done(Done), .Error(Error)
    );

    always #5 Clk = ~Clk;

    // ALU: 0 add (carry), 1 subtract (borrow), others xor (no flag)
    function automatic logic [DW:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    assign {AluFlag, AluResult} = alu_f(AluOp, AluA, AluB);

    logic [DW-1:0] mem [0:255];
    int            wr_count = 0;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;
    int            ack_delay = 0;
    logic          noack_en = 1'b0;
    logic [AW-1:0] noack_addr = '0;

    int n_cmp = 0;
    int n_fail = 0;

    // Memory responder: acks after ack_delay waiting cycles, never for noack_addr.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.MemAck   = 1'b0;
        bus.MemRData = '0;
        forever begin
            @(negedge Clk);
            if (bus.MemAck) wcnt = 0;
            bus.MemAck = 1'b0;
            if (bus.MemAccess !== 1'b1) begin
                wcnt = 0;
            end else if (noack_en && bus.MemAddr == noack_addr) begin
                wcnt++;
            end else if (wcnt >= ack_delay) begin
                bus.MemAck = 1'b1;
                if (bus.MemRW) begin
                    mem[bus.MemAddr] = bus.MemWData;
                    wr_count++;
                    last_wr_addr = bus.MemAddr;
                    last_wr_data = bus.MemWData;
                end else begin
                    bus.MemRData = mem[bus.MemAddr];
                end
            end else begin
                wcnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference expectation for the operation about to be issued
    logic [DW-1:0] exp_res, exp_a, exp_b;
    logic          exp_flag;
    logic [2:0]    exp_op;
    logic [AW-1:0] exp_r;
    int            wc0;

    task automatic expect_op(input logic [2:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] r);
        logic [DW:0] v;
        exp_a = mem[a];
        exp_b = mem[b];
        v = alu_f(op, exp_a, exp_b);
        exp_res  = v[DW-1:0];
        exp_flag = v[DW];
        exp_op   = op;
        exp_r    = r;
        wc0      = wr_count;
    endtask

    // Entered in the first cycle after the Start edge; runs to the cycle after Done.
    task automatic finish_op(input string tag, input int exp_lat, input logic exp_err);
        int n;
        logic prev_acc, prev_ack;
        logic [AW-1:0] prev_addr;
        n = 1;
        prev_acc = 1'b0;
        prev_ack = 1'b0;
        prev_addr = '0;
        chk({tag, ".err_clr"}, Error, 0);
        while (Done !== 1'b1 && n < 200) begin
            chk({tag, ".busy"}, Busy, 1);
            if (prev_acc && !prev_ack && bus.MemAccess)
                chk({tag, ".addr_stable"}, bus.MemAddr, prev_addr);
            prev_acc  = bus.MemAccess;
            prev_ack  = bus.MemAck;
            prev_addr = bus.MemAddr;
            @(negedge Clk);
            n++;
        end
        chk({tag, ".latency"}, n, exp_lat);
        chk({tag, ".busy_done"}, Busy, 0);
        chk({tag, ".acc_done"}, bus.MemAccess, 0);
        chk({tag, ".error"}, Error, exp_err);
        if (!exp_err) begin
            chk({tag, ".wr_count"}, wr_count, wc0 + 1);
            chk({tag, ".wr_addr"}, last_wr_addr, exp_r);
            chk({tag, ".wr_data"}, last_wr_data, exp_res);
            chk({tag, ".flag"}, Flag, exp_flag);
            chk({tag, ".alu_a"}, AluA, exp_a);
            chk({tag, ".alu_b"}, AluB, exp_b);
            chk({tag, ".alu_op"}, AluOp, exp_op);
        end else begin
            chk({tag, ".no_write"}, wr_count, wc0);
        end
        @(negedge Clk);
        chk({tag, ".done_1cyc"}, Done, 0);
        chk({tag, ".busy_idle"}, Busy, 0);
        if (!exp_err) chk({tag, ".flag_held"}, Flag, exp_flag);
        else          chk({tag, ".err_held"}, Error, 1);
    endtask

    task automatic drive(input logic [2:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] r);
        Opcode = op;
        AddrA  = a;
        AddrB  = b;
        AddrR  = r;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic [AW-1:0] r, input int exp_lat, input logic exp_err, input logic hold);
        drive(op, a, b, r);
        expect_op(op, a, b, r);
        Start = 1'b1;
        @(negedge Clk);
        if (!hold) Start = 1'b0;
        finish_op(tag, exp_lat, exp_err);
    endtask

    initial begin
        int found;
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        Reset = 1'b1; Active = 1'b0; Start = 1'b0;
        drive(3'd0, '0, '0, '0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        chk("rst.busy", Busy, 0);
        chk("rst.done", Done, 0);
        chk("rst.error", Error, 0);
        chk("rst.flag", Flag, 0);
        chk("rst.access", bus.MemAccess, 0);
        chk("rst.rw", bus.MemRW, 0);
        chk("rst.addr", bus.MemAddr, 0);
        chk("rst.wdata", bus.MemWData, 0);
        chk("rst.alu", {AluOp, AluA, AluB}, 0);

        Active = 1'b1;
        @(negedge Clk);
        mem[8'h10] = 8'h25; mem[8'h11] = 8'h1A;
        run_op("add", 3'd0, 8'h10, 8'h11, 8'h12, 5, 1'b0, 1'b0);
        chk("add.result", last_wr_data, 8'h3F);

        mem[8'h20] = 8'hF0; mem[8'h21] = 8'h20;
        run_op("carry", 3'd0, 8'h20, 8'h21, 8'h22, 5, 1'b0, 1'b0);
        chk("carry.result", last_wr_data, 8'h10);
        chk("carry.flag", Flag, 1);

        ack_delay = 3;
        run_op("delay3", 3'd1, 8'h30, 8'h31, 8'h32, 14, 1'b0, 1'b0);
        ack_delay = 0;

        noack_en = 1'b1; noack_addr = 8'h41;
        run_op("tmo_b", 3'd0, 8'h40, 8'h41, 8'h42, 2 + TO, 1'b1, 1'b0);
        noack_en = 1'b0;
        run_op("after_tmo", 3'd2, 8'h40, 8'h41, 8'h42, 5, 1'b0, 1'b0);

        // Active dropped in WR_R while the write is acked in the same cycle
        drive(3'd0, 8'h50, 8'h51, 8'h52);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (bus.MemAccess === 1'b1 && bus.MemRW === 1'b1) found = 1;
            else @(negedge Clk);
        end
        chk("abort.reached_wr", found, 1);
        Active = 1'b0;
        @(negedge Clk);
        chk("abort.busy", Busy, 0);
        chk("abort.done", Done, 0);
        chk("abort.access", bus.MemAccess, 0);
        Active = 1'b1;
        @(negedge Clk);
        chk("abort.done2", Done, 0);
        chk("abort.busy2", Busy, 0);

        // Start held high: one IDLE cycle between Done and the next RD_A
        run_op("b2b1", 3'd0, 8'h60, 8'h61, 8'h62, 5, 1'b0, 1'b1);
        chk("b2b.idle_access", bus.MemAccess, 0);
        expect_op(3'd0, 8'h60, 8'h61, 8'h62);
        @(negedge Clk);
        chk("b2b.rda_access", bus.MemAccess, 1);
        chk("b2b.rda_addr", bus.MemAddr, 8'h60);
        Start = 1'b0;
        finish_op("b2b2", 5, 1'b0);

        // Start with Active low stays idle
        Active = 1'b0; Start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            chk("inactive.busy", Busy, 0);
            chk("inactive.access", bus.MemAccess, 0);
        end
        Start = 1'b0; Active = 1'b1;
        @(negedge Clk);

        // Reset in the middle of an operation
        ack_delay = 2;
        drive(3'd1, 8'h70, 8'h71, 8'h72);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        chk("midrst.busy_before", Busy, 1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("midrst.busy", Busy, 0);
        chk("midrst.done", Done, 0);
        chk("midrst.access", bus.MemAccess, 0);
        chk("midrst.regs", {AluA, AluB, Flag, Error}, 0);
        repeat (3) begin
            @(negedge Clk);
            chk("midrst.no_done", Done, 0);
        end

        // Randomized operations against the reference
        for (int k = 0; k < 10; k++) begin
            logic [2:0] op;
            logic [AW-1:0] a, b, r;
            int d;
            op = 3'($urandom_range(0, 3));
            a  = AW'($urandom_range(128, 255));
            b  = AW'($urandom_range(128, 255));
            r  = AW'($urandom_range(128, 255));
            d  = $urandom_range(0, 3);
            ack_delay = d;
            run_op("rand", op, a, b, r, 5 + 3 * d, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Sequences one binary-calculator operation over the shared operand memory and the external ALU: reads operand A, reads operand B, executes the ALU, and writes the result back. It sits between the command/key controller, which supplies `Active` and the operation request, and the memory and ALU datapath. It uses a request/acknowledge handshake on the memory side, with a per-access timeout. It reports `Busy`, a one-cycle `Done` pulse, a sticky `Error` and the latched ALU flag.

## Interface
- `DATA_WIDTH`, 8, operand/result width
- `ADDR_WIDTH`, 8, memory address width
- `TIMEOUT`, 15, max cycles a memory access waits for `MemAck` (≥1)
- `Clk`  in  1  single clock; all logic on rising edge
- `Reset`  in  1  synchronous, active-high
- `Active`  in  1  calculator enabled (from key decoder); low aborts any operation
- `Start`  in  1  operation request, sampled only in IDLE
- `Opcode`  in  3  ALU operation code, forwarded unchanged
- `AddrA`, `AddrB`, `AddrR`  in  ADDR_WIDTH each  operand A / operand B / result addresses
- `MemAccess`  out  1  memory request, held until acknowledged
- `MemRW`  out  1  0 = read, 1 = write
- `MemAddr`  out  ADDR_WIDTH  access address
- `MemWData`  out  DATA_WIDTH  write data
- `MemRData`  in  DATA_WIDTH  read data, valid in the `MemAck` cycle
- `MemAck`  in  1  access complete; one cycle
- `AluOp`  out  3  latched opcode
- `AluA`, `AluB`  out  DATA_WIDTH  latched operands
- `AluResult`  in  DATA_WIDTH  combinational ALU result
- `AluFlag`  in  1  ALU carry/overflow
- `Flag`  out  1  `AluFlag` captured at EXEC
- `Busy`  out  1  operation in progress
- `Done`  out  1  one-cycle completion pulse
- `Error`  out  1  sticky timeout indication

## Operation
- States: IDLE, RD_A, RD_B, EXEC, WR_R, DONE. Encoding is free.
- IDLE: when `Start & Active` is sampled, latch `Opcode`, `AddrA`, `AddrB` and `AddrR`, clear `Error` and `Flag`, and go to RD_A. Otherwise stay in IDLE.
- RD_A and RD_B:
  - Drive `MemAccess=1`, `MemRW=0`, `MemAddr` = latched AddrA or AddrB.
  - On `MemAck`, capture `MemRData` into A or B and advance (RD_A → RD_B → EXEC).
- EXEC: exactly one cycle. Capture `AluResult` into the result register and `AluFlag` into `Flag`, then go to WR_R.
- WR_R: drive `MemAccess=1`, `MemRW=1`, `MemAddr` = latched AddrR, `MemWData` = result. On `MemAck`, go to DONE.
- DONE: `Done=1` for one cycle, then go to IDLE unconditionally. `Start` is ignored in DONE.
- `AluOp`, `AluA` and `AluB` always reflect the latched registers.
- `MemWData` is the result register. It is valid in WR_R and don't-care elsewhere.
- `MemAddr` is 0 when `MemAccess=0`.
- Timeout:
  - A wait counter clears on entry to each memory state and increments every cycle without `MemAck`.
  - When the counter reaches `TIMEOUT` without an ack, set `Error=1`, drop `MemAccess`, and go to DONE. `Done` still pulses and no further accesses are made.
- `MemAck` outside RD_A, RD_B or WR_R is ignored.
- `MemAck` arriving in the same cycle the counter hits `TIMEOUT` counts as success; the ack wins.
- `Active` low in any non-IDLE state, including DONE:
  - Go to IDLE on the next edge and drop `MemAccess`.
  - No `Done` pulse; `Error` unchanged.
  - `Active` low has priority over `MemAck`.
- `Busy=1` in RD_A, RD_B, EXEC and WR_R; 0 in IDLE and DONE.

## Timing
- Reset, synchronous: state IDLE, all registers 0. `MemAccess`, `MemRW`, `MemAddr`, `MemWData`, `AluOp`, `AluA`, `AluB`, `Flag`, `Busy`, `Done` and `Error` are all 0 the cycle after `Reset` is sampled.
- Reset mid-operation has the same effect; `Done` does not pulse.
- All outputs are registered or decoded from state and latched registers; there are no combinational paths from inputs to outputs.
- `Start` sampled at edge T: RD_A is active (`Busy=1`, `MemAccess=1`) from T+1.
- With `MemAck` in the first cycle of every access: RD_A at T+1, RD_B at T+2, EXEC at T+3, WR_R at T+4, `Done` at T+5. Each access adds one cycle per cycle of ack delay.
- Timeout case: `MemAck` never arrives in RD_A, so `Error` and `Done` rise in the same cycle, T+1+`TIMEOUT`.
- Back-to-back: a new `Start` is accepted at the edge after DONE, i.e. at the earliest in the IDLE cycle at T+6.

## Test plan
- Reset, then `Active=1`, `Start` with AddrA=0x10, AddrB=0x11, AddrR=0x12, `Opcode`=0 (add), memory returns 0x25 and 0x1A with immediate acks, ALU model returns 0x3F → write of 0x3F to 0x12 in T+4, `Done` at T+5, `Busy` high T+1..T+4, `Flag`=0.
- Same, but operands 0xF0 and 0x20 with the ALU flagging carry → `MemWData`=0x10, `Flag`=1 held after `Done`.
- Ack delayed 3 cycles on each access → `Done` at T+14; `MemAccess` and `MemAddr` stable throughout each wait.
- No ack in RD_B with `TIMEOUT`=15 → `MemAccess` drops, `Error`=1 and `Done` pulse 15 cycles after RD_B entry, no write issued; the next `Start` clears `Error`.
- `Active` dropped during WR_R with `MemAck` in the same cycle → next cycle IDLE, `Busy`=0, no `Done`.
- `Start` held high continuously, or `Start` with `Active`=0 → operations issue back-to-back with exactly one IDLE cycle between `Done` and the next RD_A; the `Active`=0 case stays in IDLE with no `MemAccess`.
